// File: rtl/stacker_controller.sv
// Stacker arcade game controller: sweeps a stack of blocks across the playfield,
// trims it against the row below on each drop, and issues row draw requests.
module stacker_controller #(
  parameter int STEP_DIV    = 4,
  parameter int NUM_COLS    = 13,
  parameter int NUM_ROWS    = 10,
  parameter int START_WIDTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       drop,
  input  logic       draw_ack,
  output logic       draw_req,
  output logic [9:0] draw_x,
  output logic [8:0] draw_y,
  output logic [7:0] draw_len,
  output logic [3:0] row,
  output logic       game_over,
  output logic       game_won
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [1:0]    W_INIT    = 2'(START_WIDTH);
  localparam logic [3:0]    ROW_LAST  = 4'(NUM_ROWS - 1);
  localparam logic [4:0]    COL_LIMIT = 5'(NUM_COLS);

  typedef enum logic [2:0] {IDLE, DRAW, MOVE, EVAL, LOSE, WIN} state_t;
  typedef enum logic {RET_MOVE, RET_NEXT} ret_t;

  state_t          state;
  ret_t            ret;
  logic [3:0]      col, prev_col;
  logic [1:0]      width, prev_width;
  logic            dir;
  logic [TW-1:0]   tick;

  logic [3:0]      step_col;
  logic            step_dir;
  logic [4:0]      span_end, prev_end, left, right;
  logic [3:0]      eval_col;
  logic [1:0]      eval_width;
  logic            eval_fail;

  function automatic logic [9:0] px_x(input logic [3:0] c);
    return 10'(c) * 10'd48;
  endfunction

  function automatic logic [8:0] px_y(input logic [3:0] r);
    return 9'd432 - 9'(r) * 9'd48;
  endfunction

  function automatic logic [7:0] px_len(input logic [1:0] w);
    return 8'(w) * 8'd48;
  endfunction

  assign span_end = {1'b0, col} + {3'b0, width};
  assign prev_end = {1'b0, prev_col} + {3'b0, prev_width};

  // Reverse at the walls by stepping back immediately, so the stack never overruns.
  always_comb begin
    step_col = col;
    step_dir = dir;
    if (!dir && span_end == COL_LIMIT) begin
      step_dir = 1'b1;
      step_col = col - 4'd1;
    end else if (dir && col == 4'd0) begin
      step_dir = 1'b0;
      step_col = col + 4'd1;
    end else begin
      step_col = dir ? col - 4'd1 : col + 4'd1;
    end
  end

  always_comb begin
    left       = (col > prev_col) ? {1'b0, col} : {1'b0, prev_col};
    right      = (span_end < prev_end) ? span_end : prev_end;
    eval_fail  = 1'b0;
    eval_col   = col;
    eval_width = width;
    if (row != 4'd0) begin
      eval_fail  = (right <= left);
      eval_col   = left[3:0];
      eval_width = 2'(right - left);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ret        <= RET_MOVE;
      draw_req   <= 1'b0;
      draw_x     <= '0;
      draw_y     <= 9'd432;
      draw_len   <= px_len(W_INIT);
      row        <= '0;
      game_over  <= 1'b0;
      game_won   <= 1'b0;
      col        <= '0;
      width      <= W_INIT;
      dir        <= 1'b0;
      tick       <= '0;
      prev_col   <= '0;
      prev_width <= '0;
    end else begin
      case (state)
        IDLE, LOSE, WIN: begin
          if (start) begin
            row       <= '0;
            col       <= '0;
            dir       <= 1'b0;
            width     <= W_INIT;
            tick      <= '0;
            ret       <= RET_MOVE;
            state     <= DRAW;
            draw_req  <= 1'b1;
            draw_x    <= '0;
            draw_y    <= px_y(4'd0);
            draw_len  <= px_len(W_INIT);
            game_over <= 1'b0;
            game_won  <= 1'b0;
          end
        end
        DRAW: begin
          if (draw_ack) begin
            if (ret == RET_MOVE) begin
              draw_req <= 1'b0;
              state    <= MOVE;
            end else if (row == ROW_LAST) begin
              draw_req <= 1'b0;
              game_won <= 1'b1;
              state    <= WIN;
            end else begin
              // Advancing a row goes straight into the next draw, so draw_req stays high.
              row      <= row + 4'd1;
              col      <= '0;
              dir      <= 1'b0;
              tick     <= '0;
              ret      <= RET_MOVE;
              draw_x   <= '0;
              draw_y   <= px_y(row + 4'd1);
              draw_len <= px_len(width);
            end
          end
        end
        MOVE: begin
          if (drop) begin
            state <= EVAL;
          end else if (tick == TICK_LAST) begin
            tick     <= '0;
            col      <= step_col;
            dir      <= step_dir;
            ret      <= RET_MOVE;
            state    <= DRAW;
            draw_req <= 1'b1;
            draw_x   <= px_x(step_col);
            draw_y   <= px_y(row);
            draw_len <= px_len(width);
          end else begin
            tick <= tick + 1'b1;
          end
        end
        EVAL: begin
          if (eval_fail) begin
            game_over <= 1'b1;
            state     <= LOSE;
          end else begin
            col        <= eval_col;
            width      <= eval_width;
            prev_col   <= eval_col;
            prev_width <= eval_width;
            ret        <= RET_NEXT;
            state      <= DRAW;
            draw_req   <= 1'b1;
            draw_x     <= px_x(eval_col);
            draw_y     <= px_y(row);
            draw_len   <= px_len(eval_width);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stacker_controller.sv
// Directed testbench for stacker_controller with default parameters.
module tb_stacker_controller;

  logic       clk = 1'b0;
  logic       reset, start, drop, draw_ack;
  logic       draw_req;
  logic [9:0] draw_x;
  logic [8:0] draw_y;
  logic [7:0] draw_len;
  logic [3:0] row;
  logic       game_over, game_won;

  int tests = 0;
  int fails = 0;

  stacker_controller #(
    .STEP_DIV(4), .NUM_COLS(13), .NUM_ROWS(10), .START_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .drop(drop), .draw_ack(draw_ack),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_len(draw_len),
    .row(row), .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; drop = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (draw_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  // Starts from a sampled draw of the current row; drops once the stack is drawn at column c.
  task automatic drop_at(input int c, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (draw_req === 1'b1 && draw_x == 10'(c * 48)) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    cyc();
    drop = 1'b1;
    cyc();
    drop = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    draw_ack = 1'b0;
    do_reset();
    tests++; if (draw_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0d expected 0", draw_req); end
    tests++; if (draw_x !== 10'd0) begin fails++; $display("FAIL reset_x: got %0d expected 0", draw_x); end
    tests++; if (draw_y !== 9'd432) begin fails++; $display("FAIL reset_y: got %0d expected 432", draw_y); end
    tests++; if (draw_len !== 8'd144) begin fails++; $display("FAIL reset_len: got %0d expected 144", draw_len); end
    tests++; if (row !== 4'd0) begin fails++; $display("FAIL reset_row: got %0d expected 0", row); end
    tests++; if (game_over !== 1'b0 || game_won !== 1'b0) begin fails++; $display("FAIL reset_flags: got %0d/%0d expected 0/0", game_over, game_won); end
    drop = 1'b1;
    cyc();
    drop = 1'b0;
    tests++; if (draw_req !== 1'b0) begin fails++; $display("FAIL idle_drop_ignored: got %0d expected 0", draw_req); end
  endtask

  task automatic test_first_step();
    do_reset();
    draw_ack = 1'b1;
    do_start();
    tests++; if (draw_req !== 1'b1) begin fails++; $display("FAIL start_req: got %0d expected 1", draw_req); end
    tests++; if (draw_x !== 10'd0 || draw_y !== 9'd432 || draw_len !== 8'd144) begin fails++; $display("FAIL start_fields: got %0d,%0d,%0d expected 0,432,144", draw_x, draw_y, draw_len); end
    cyc();
    tests++; if (draw_req !== 1'b0) begin fails++; $display("FAIL ack_drops_req: got %0d expected 0", draw_req); end
    cyc(); cyc(); cyc();
    tests++; if (draw_req !== 1'b0) begin fails++; $display("FAIL no_early_step: got %0d expected 0", draw_req); end
    cyc();
    tests++; if (draw_req !== 1'b1 || draw_x !== 10'd48) begin fails++; $display("FAIL first_step: got req=%0d x=%0d expected req=1 x=48", draw_req, draw_x); end
  endtask

  task automatic test_bounce();
    bit ok;
    int exp_col;
    do_reset();
    draw_ack = 1'b1;
    do_start();
    for (int i = 0; i < 22; i++) begin
      if (i > 0) begin
        cyc();
        wait_req(ok);
        tests++; if (!ok) begin fails++; $display("FAIL bounce_timeout: got no draw_req expected draw %0d", i); end
      end
      exp_col = (i <= 10) ? i : ((i <= 20) ? 20 - i : i - 20);
      tests++; if (draw_x !== 10'(exp_col * 48) || draw_x > 10'd480) begin fails++; $display("FAIL bounce_x[%0d]: got %0d expected %0d", i, draw_x, exp_col * 48); end
    end
  endtask

  task automatic test_trim();
    bit ok;
    do_reset();
    draw_ack = 1'b1;
    do_start();
    drop_at(5, ok);
    tests++; if (!ok || draw_req !== 1'b1 || draw_x !== 10'd240 || draw_y !== 9'd432 || draw_len !== 8'd144) begin fails++; $display("FAIL row0_place: got ok=%0d req=%0d x=%0d y=%0d len=%0d expected 1,1,240,432,144", ok, draw_req, draw_x, draw_y, draw_len); end
    cyc();
    tests++; if (row !== 4'd1 || draw_req !== 1'b1 || draw_y !== 9'd384) begin fails++; $display("FAIL row1_begin: got row=%0d req=%0d y=%0d expected 1,1,384", row, draw_req, draw_y); end
    drop_at(6, ok);
    tests++; if (!ok || draw_x !== 10'd288 || draw_len !== 8'd96 || draw_y !== 9'd384) begin fails++; $display("FAIL trim_draw: got ok=%0d x=%0d len=%0d y=%0d expected 1,288,96,384", ok, draw_x, draw_len, draw_y); end
    tests++; if (draw_req !== 1'b1 || row !== 4'd1) begin fails++; $display("FAIL trim_req_row: got req=%0d row=%0d expected 1,1", draw_req, row); end
    cyc();
    tests++; if (row !== 4'd2 || draw_x !== 10'd0 || draw_y !== 9'd336 || draw_len !== 8'd96) begin fails++; $display("FAIL row2_begin: got row=%0d x=%0d y=%0d len=%0d expected 2,0,336,96", row, draw_x, draw_y, draw_len); end
  endtask

  task automatic test_lose();
    bit ok;
    bit seen_req;
    do_reset();
    draw_ack = 1'b1;
    do_start();
    drop_at(5, ok);
    cyc();
    drop_at(9, ok);
    tests++; if (!ok || game_over !== 1'b1 || draw_req !== 1'b0) begin fails++; $display("FAIL lose_enter: got ok=%0d over=%0d req=%0d expected 1,1,0", ok, game_over, draw_req); end
    tests++; if (game_won !== 1'b0 || row !== 4'd1) begin fails++; $display("FAIL lose_state: got won=%0d row=%0d expected 0,1", game_won, row); end
    seen_req = 1'b0;
    drop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (draw_req !== 1'b0 || game_over !== 1'b1) seen_req = 1'b1;
    end
    drop = 1'b0;
    tests++; if (seen_req) begin fails++; $display("FAIL lose_hold: got activity expected idle LOSE"); end
    do_start();
    tests++; if (row !== 4'd0 || draw_req !== 1'b1 || draw_len !== 8'd144 || draw_x !== 10'd0 || game_over !== 1'b0) begin fails++; $display("FAIL restart: got row=%0d req=%0d len=%0d x=%0d over=%0d expected 0,1,144,0,0", row, draw_req, draw_len, draw_x, game_over); end
  endtask

  task automatic test_drop_on_tick();
    bit stable;
    do_reset();
    draw_ack = 1'b1;
    do_start();
    cyc();
    cyc(); cyc(); cyc();
    drop = 1'b1;
    draw_ack = 1'b0;
    cyc();
    drop = 1'b0;
    tests++; if (draw_req !== 1'b0) begin fails++; $display("FAIL drop_no_step: got req=%0d expected 0", draw_req); end
    cyc();
    tests++; if (draw_req !== 1'b1 || draw_x !== 10'd0) begin fails++; $display("FAIL drop_eval_draw: got req=%0d x=%0d expected 1,0", draw_req, draw_x); end
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (draw_req !== 1'b1 || draw_x !== 10'd0 || draw_y !== 9'd432 || draw_len !== 8'd144 || row !== 4'd0) stable = 1'b0;
    end
    tests++; if (!stable) begin fails++; $display("FAIL stall_stable: got change expected req=1 x=0 y=432 len=144"); end
    draw_ack = 1'b1;
    cyc();
    tests++; if (row !== 4'd1 || draw_y !== 9'd384 || draw_x !== 10'd0) begin fails++; $display("FAIL stall_release: got row=%0d y=%0d x=%0d expected 1,384,0", row, draw_y, draw_x); end
  endtask

  task automatic test_win();
    bit ok;
    do_reset();
    draw_ack = 1'b1;
    do_start();
    for (int r = 0; r < 10; r++) begin
      drop_at(0, ok);
      tests++; if (!ok || draw_req !== 1'b1 || draw_len !== 8'd144 || row !== 4'(r)) begin fails++; $display("FAIL win_row[%0d]: got ok=%0d req=%0d len=%0d row=%0d expected 1,1,144,%0d", r, ok, draw_req, draw_len, row, r); end
      cyc();
    end
    tests++; if (game_won !== 1'b1 || game_over !== 1'b0 || draw_req !== 1'b0) begin fails++; $display("FAIL win_flags: got won=%0d over=%0d req=%0d expected 1,0,0", game_won, game_over, draw_req); end
    tests++; if (row !== 4'd9 || draw_len !== 8'd144) begin fails++; $display("FAIL win_row_width: got row=%0d len=%0d expected 9,144", row, draw_len); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; drop = 1'b0; draw_ack = 1'b0;
    test_reset();
    test_first_step();
    test_bounce();
    test_trim();
    test_lose();
    test_drop_on_tick();
    test_win();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stacker_controller.md
STACKER_CONTROLLER -- requirements
Module: stacker_controller

Interface
REQ-001 Parameter STEP_DIV, default 4: clock cycles per one-column move step.
REQ-002 Parameter NUM_COLS, default 13: playfield columns of 48 px (0..12).
REQ-003 Parameter NUM_ROWS, default 10: playfield rows of 48 px (0..9, row 0 at bottom).
REQ-004 Parameter START_WIDTH, default 3: initial stack width in columns (1..3).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins or restarts a game.
REQ-008 drop  in  1  one-cycle pulse; player stop button.
REQ-009 draw_ack  in  1  datapath accepted current draw request.
REQ-010 draw_req  out  1  draw request, held until acknowledged.
REQ-011 draw_x  out  10  pixel x of stack left edge = col*48.
REQ-012 draw_y  out  9  pixel y of row top = 432 - 48*row.
REQ-013 draw_len  out  8  pixel length = width*48; datapath clears the whole row, then paints this span.
REQ-014 row  out  4  current row index (equals rows placed).
REQ-015 game_over  out  1  high in LOSE.
REQ-016 game_won  out  1  high in WIN.

Function
REQ-017 States: IDLE, DRAW, MOVE, EVAL, LOSE, WIN; internal regs col[3:0], width[1:0], dir (0 = right), tick counter, prev_col, prev_width, ret (DRAW return target: MOVE or NEXT).
REQ-018 Game init on start in IDLE, LOSE or WIN: row=0, col=0, dir=0, width=START_WIDTH, tick=0; go to DRAW with ret=MOVE. Start is ignored in all other states.
REQ-019 DRAW: draw_req=1; draw_x/y/len from col/row/width and constant while draw_req=1; in the draw_ack cycle, draw_req deasserts on the next edge and state goes to ret.
REQ-020 MOVE: tick increments every cycle; at tick==STEP_DIV-1 without drop, tick->0, a step applies and state->DRAW (ret=MOVE).
REQ-021 Step: dir=0 and col+width==NUM_COLS -> dir=1, col=col-1; dir=1 and col==0 -> dir=0, col=col+1; else col +/- 1 per dir. The stack never leaves 0..NUM_COLS-1.
REQ-022 drop in MOVE -> EVAL next cycle; drop wins over a simultaneous step tick (no step). drop in any other state is ignored.
REQ-023 EVAL (one cycle), row 0: placement accepted unchanged.
REQ-024 EVAL, row>0: left=max(col,prev_col), right=min(col+width, prev_col+prev_width) in 5-bit unsigned; right<=left -> LOSE; else col=left, width=right-left.
REQ-025 On acceptance: prev_col=col, prev_width=width (post-trim); state->DRAW with ret=NEXT, repainting the trimmed row.
REQ-026 NEXT (taken on DRAW exit): row==NUM_ROWS-1 -> WIN with row unchanged; else row=row+1, col=0, dir=0, tick=0, width kept, DRAW with ret=MOVE.
REQ-027 LOSE/WIN hold all registers; game_over/game_won high only in the respective state; draw_req=0.
REQ-028 draw_ack while draw_req=0 is ignored.

Reset
REQ-029 reset dominates all inputs; next edge: IDLE, draw_req=0, draw_x=0, draw_y=432, draw_len=START_WIDTH*48 (144), row=0, game_over=0, game_won=0, col=0, dir=0, tick=0, prev_col=0, prev_width=0.
REQ-030 reset mid-draw drops draw_req on the next edge regardless of draw_ack.

Verification
REQ-031 Reset, start, draw_ack tied 1 -> draw_req, x=0, y=432, len=144; MOVE; first step after 4 cycles -> draw x=48.
REQ-032 Bounce: width 3, ack tied 1, no drop -> col 0..10, then 9 with dir=1, down to 0, then 1; draw_x never >480.
REQ-033 Row 0 drop at col 5, then row 1 drop at col 6 -> EVAL trims to col 6, width 2; draw x=288, len=96, y=384; row becomes 2.
REQ-034 Row 1 drop at col 9 over row 0 at col 5 (width 3) -> LOSE, game_over=1, no further draw_req; start -> row 0, width 3, DRAW.
REQ-035 drop on same cycle as tick==3 -> no step, EVAL; draw_ack held 0 for 5 cycles -> draw_req and fields stable throughout.
REQ-036 Perfect aligned drops on all 10 rows -> WIN after row 9 draw, game_won=1, row=9, width 3.
